// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the two-read/one-write RAM BIST: geometry,
// controller state encoding and the background data pattern.
package ram_bist_pkg;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = DEPTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_R0,
    S_W1,
    S_R1,
    S_DONE
  } state_t;

  // Background pattern: seed XOR zero-extended address.
  function automatic logic [DW-1:0] pat(input logic [DW-1:0] seed, input logic [AW-1:0] a);
    return seed ^ {{(DW-AW){1'b0}}, a};
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Issue-to-compare pipeline: registers the expected words and addresses at
// issue and flags mismatches against the RAM read data one cycle later.
module ram_bist_cmp #(
  parameter int             AW   = ram_bist_pkg::AW,
  parameter int             DW   = ram_bist_pkg::DW,
  parameter logic [DW-1:0]  SEED = 32'hA5A5_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_i,
  input  logic          inv_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [AW-1:0] addr2_i,
  input  logic [DW-1:0] dout1_i,
  input  logic [DW-1:0] dout2_i,
  output logic          miss1_o,
  output logic          miss2_o,
  output logic [AW-1:0] addr1_o,
  output logic [AW-1:0] addr2_o
);
  import ram_bist_pkg::*;

  logic          vld_q;
  logic [DW-1:0] exp1_q, exp2_q;
  logic [AW-1:0] addr1_q, addr2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      exp1_q  <= '0;
      exp2_q  <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      vld_q <= issue_i;
      if (issue_i) begin
        exp1_q  <= inv_i ? ~pat(SEED, addr1_i) : pat(SEED, addr1_i);
        exp2_q  <= inv_i ? ~pat(SEED, addr2_i) : pat(SEED, addr2_i);
        addr1_q <= addr1_i;
        addr2_q <= addr2_i;
      end
    end
  end

  assign miss1_o = vld_q && (dout1_i != exp1_q);
  assign miss2_o = vld_q && (dout2_i != exp2_q);
  assign addr1_o = addr1_q;
  assign addr2_o = addr2_q;

endmodule

// File: rtl/ram_2r1w_bist.sv
// March-style BIST controller for a 2R1W RAM: write pattern, read back on both
// ports, write inverted pattern descending, read back. BIST_ERR_CNT_EN adds a
// saturating err_cnt output and runs to completion instead of aborting.
module ram_2r1w_bist #(
  parameter int             AW   = ram_bist_pkg::AW,
  parameter int             DW   = ram_bist_pkg::DW,
  parameter logic [DW-1:0]  SEED = 32'hA5A5_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic          we,
  output logic [AW-1:0] addrw,
  output logic [DW-1:0] dinw,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  input  logic [DW-1:0] dout1,
  input  logic [DW-1:0] dout2
`ifdef BIST_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);
  import ram_bist_pkg::*;

  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_HALF = {1'b1, {(AW-1){1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;

  logic          in_read, issue, any_miss;
  logic          miss1, miss2;
  logic [AW-1:0] cmp_addr1, cmp_addr2;

  assign in_read  = (state_q == S_R0) || (state_q == S_R1);
  // Read phases count 0..HALF: the top count is the drain cycle with no issue.
  assign issue    = in_read && !cnt_q[AW-1];
  assign any_miss = in_read && (miss1 || miss2);

  ram_bist_cmp #(.AW(AW), .DW(DW), .SEED(SEED)) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .issue_i (issue),
    .inv_i   (state_q == S_R1),
    .addr1_i (cnt_q),
    .addr2_i (cnt_q | ADDR_HALF),
    .dout1_i (dout1),
    .dout2_i (dout2),
    .miss1_o (miss1),
    .miss2_o (miss2),
    .addr1_o (cmp_addr1),
    .addr2_o (cmp_addr2)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    busy        = 1'b0;
    done        = 1'b0;
    we          = 1'b0;
    addrw       = '0;
    dinw        = '0;
    addr1       = '0;
    addr2       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_W0;
          cnt_d       = '0;
          err_d       = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      S_W0: begin
        busy  = 1'b1;
        we    = 1'b1;
        addrw = cnt_q;
        dinw  = pat(SEED, cnt_q);
        if (cnt_q == ADDR_LAST) begin
          state_d = S_R0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_R0, S_R1: begin
        busy = 1'b1;
        if (issue) begin
          addr1 = cnt_q;
          addr2 = cnt_q | ADDR_HALF;
        end
        if (cnt_q == ADDR_HALF) begin
          state_d = (state_q == S_R0) ? S_W1 : S_DONE;
          cnt_d   = (state_q == S_R0) ? ADDR_LAST : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_W1: begin
        busy  = 1'b1;
        we    = 1'b1;
        addrw = cnt_q;
        dinw  = ~pat(SEED, cnt_q);
        if (cnt_q == '0) begin
          state_d = S_R1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (any_miss) begin
      if (!err_q) begin
        fail_addr_d = miss1 ? cmp_addr1 : cmp_addr2;
      end
      err_d = 1'b1;
`ifndef BIST_ERR_CNT_EN
      state_d = S_DONE;
`endif
    end

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      pass_d = !err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;

`ifdef BIST_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + {16'd0, miss1} + {16'd0, miss2};
    err_cnt_d = err_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      err_cnt_d = '0;
    end else if (any_miss) begin
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ram_2r1w_bist.sv
// Self-checking bench for ram_2r1w_bist: behavioural 2R1W RAM with fault
// injection, timeline reference model and randomized fault/start scenarios.
module tb_ram_2r1w_bist;

  localparam int          AW      = 11;
  localparam int          DW      = 32;
  localparam int          DEPTH   = 2048;
  localparam int          HALF    = 1024;
  localparam logic [31:0] SEED    = 32'hA5A5_0000;
  localparam int          R0_BASE = DEPTH;
  localparam int          W1_BASE = DEPTH + HALF + 1;
  localparam int          R1_BASE = 2 * DEPTH + HALF + 1;
  localparam int          RUN_LEN = 2 * DEPTH + 2 * (HALF + 1);
`ifdef BIST_ERR_CNT_EN
  localparam bit          CNT_MODE = 1'b1;
`else
  localparam bit          CNT_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass, we;
  logic [AW-1:0] fail_addr, addrw, addr1, addr2;
  logic [DW-1:0] dinw, dout1, dout2;
`ifdef BIST_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  ram_2r1w_bist dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .we        (we),
    .addrw     (addrw),
    .dinw      (dinw),
    .addr1     (addr1),
    .addr2     (addr2),
    .dout1     (dout1),
    .dout2     (dout2)
`ifdef BIST_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    int          phase;
    int          port;
    int          addr;
    logic [31:0] mask;
    bit          is_or;
  } fault_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addrw;
    logic [DW-1:0] dinw;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          busy;
    logic          done;
  } bus_t;

  fault_t      faults[$];
  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miscmp = 0;

  function automatic logic [31:0] tb_pat(input int a);
    return SEED ^ 32'(a);
  endfunction

  function automatic logic [31:0] corrupt(input logic [31:0] v, input int ph, input int port, input int addr);
    logic [31:0] r;
    r = v;
    foreach (faults[i]) begin
      if (faults[i].phase == ph && faults[i].port == port && faults[i].addr == addr)
        r = faults[i].is_or ? (r | faults[i].mask) : (r ^ faults[i].mask);
    end
    return r;
  endfunction

  // Behavioural RAM: one write port, two registered read ports with faults.
  always @(posedge clk) begin
    if (we) mem[addrw] <= dinw;
    dout1 <= corrupt(mem[addr1], (cyc >= W1_BASE) ? 1 : 0, 1, int'(addr1));
    dout2 <= corrupt(mem[addr2], (cyc >= W1_BASE) ? 1 : 0, 2, int'(addr2));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks both read phases address by address and finds where the run ends.
  task automatic model_run(output int end_cyc, output bit exp_pass,
                           output int exp_faddr, output int exp_nerr);
    bit          seen, stop, m1, m2;
    logic [31:0] e1, e2;
    seen = 0; stop = 0;
    end_cyc = RUN_LEN; exp_faddr = 0; exp_nerr = 0;
    for (int p = 0; p < 2 && !stop; p++) begin
      for (int a = 0; a < HALF && !stop; a++) begin
        e1 = p ? ~tb_pat(a) : tb_pat(a);
        e2 = p ? ~tb_pat(a + HALF) : tb_pat(a + HALF);
        m1 = corrupt(e1, p, 1, a) != e1;
        m2 = corrupt(e2, p, 2, a + HALF) != e2;
        if (m1 || m2) begin
          exp_nerr += int'(m1) + int'(m2);
          if (!seen) begin
            seen = 1;
            exp_faddr = m1 ? a : a + HALF;
            if (!CNT_MODE) begin
              end_cyc = (p ? R1_BASE : R0_BASE) + a + 2;
              stop = 1;
            end
          end
        end
      end
    end
    exp_pass = (exp_nerr == 0);
    if (exp_nerr > 65535) exp_nerr = 65535;
  endtask

  function automatic bus_t expect_at(input int c, input int e);
    bus_t x;
    x = '0;
    if (c == e) begin
      x.done = 1'b1;
    end else if (c < e) begin
      x.busy = 1'b1;
      if (c < R0_BASE) begin
        x.we = 1'b1; x.addrw = AW'(c); x.dinw = tb_pat(c);
      end else if (c < W1_BASE) begin
        if (c - R0_BASE < HALF) begin
          x.a1 = AW'(c - R0_BASE); x.a2 = AW'(c - R0_BASE + HALF);
        end
      end else if (c < R1_BASE) begin
        x.we = 1'b1; x.addrw = AW'(R1_BASE - 1 - c); x.dinw = ~tb_pat(R1_BASE - 1 - c);
      end else if (c - R1_BASE < HALF) begin
        x.a1 = AW'(c - R1_BASE); x.a2 = AW'(c - R1_BASE + HALF);
      end
    end
    return x;
  endfunction

  task automatic run_bist(input string name, input int restart_at);
    int   e, faddr, nerr, done_cyc, dev, first_dev;
    bit   epass;
    bus_t x, obs;
    model_run(e, epass, faddr, nerr);
    done_cyc = -1; dev = 0; first_dev = -1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= e + 1 && c < RUN_LEN + 8; c++) begin
      cyc = c;
      x   = expect_at(c, e);
      obs = {we, addrw, dinw, addr1, addr2, busy, done};
      if (done && done_cyc < 0) done_cyc = c;
      if (obs !== x) begin
        if (dev == 0) first_dev = c;
        dev++;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "/done_latency"}, 64'(done_cyc), 64'(e));
    check({name, "/pass"}, 64'(pass), 64'(epass));
    check({name, "/fail_addr"}, 64'(fail_addr), 64'(faddr));
    check($sformatf("%s/bus_deviations_from_cycle_%0d", name, first_dev), 64'(dev), 64'(0));
`ifdef BIST_ERR_CNT_EN
    check({name, "/err_cnt"}, 64'(err_cnt), 64'(nerr));
`endif
  endtask

  task automatic reset_mid_run();
    int stray;
    faults.delete();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < W1_BASE + 100; c++) begin
      cyc = c;
      @(negedge clk);
    end
    cyc = W1_BASE + 100;
    check("rst/we_before", 64'(we), 64'(1));
    check("rst/addrw_before", 64'(addrw), 64'(DEPTH - 1 - 100));
    #1 rst = 1'b1;
    #1;
    check("rst/we", 64'(we), 64'(0));
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/addrw", 64'(addrw), 64'(0));
    check("rst/done_pass_faddr", {done, pass, fail_addr}, '0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (we || busy || done) stray++;
    end
    check("rst/no_activity_after_release", 64'(stray), 64'(0));
  endtask

  initial begin
    fault_t f;
    int     nf;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/done", 64'(done), 64'(0));
    check("reset/pass", 64'(pass), 64'(0));
    check("reset/fail_addr", 64'(fail_addr), 64'(0));
    check("reset/write_side", {we, addrw, dinw}, '0);
    check("reset/read_side", {addr1, addr2}, '0);
`ifdef BIST_ERR_CNT_EN
    check("reset/err_cnt", 64'(err_cnt), 64'(0));
`endif
    rst = 1'b0;

    // Clean run with an ignored start pulse part-way through W0.
    faults.delete();
    run_bist("clean", 500);

    // Bit 5 of port 2 stuck high at address 1030 during R0.
    faults.delete();
    f = '{phase: 0, port: 2, addr: HALF + 6, mask: 32'h20, is_or: 1'b1};
    faults.push_back(f);
    run_bist("stuck_bit", -1);

    // Both ports miss in the same R1 cycle; port 1's address must win.
    faults.delete();
    f = '{phase: 1, port: 1, addr: 3, mask: 32'h1, is_or: 1'b0};
    faults.push_back(f);
    f = '{phase: 1, port: 2, addr: HALF + 3, mask: 32'h8000_0000, is_or: 1'b0};
    faults.push_back(f);
    run_bist("dual_miss", -1);

    reset_mid_run();

    faults.delete();
    run_bist("clean_after_reset", -1);

    for (int r = 0; r < 4; r++) begin
      faults.delete();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        f.phase = $urandom_range(0, 1);
        f.port  = $urandom_range(1, 2);
        f.addr  = (f.port == 1) ? $urandom_range(0, HALF - 1) : $urandom_range(HALF, DEPTH - 1);
        f.mask  = $urandom;
        if (f.mask == 0) f.mask = 32'h1;
        f.is_or = 1'($urandom_range(0, 1));
        faults.push_back(f);
      end
      run_bist($sformatf("random%0d", r), $urandom_range(1, 2040));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/ram_2r1w_bist.md
RAM_2R1W_BIST -- requirements
Module: ram_2r1w_bist

Interface
REQ-001 The block SHALL have parameter AW, default 11, meaning RAM address width (depth 2**AW = 2048).
REQ-002 The block SHALL have parameter DW, default 32, meaning RAM data width.
REQ-003 The block SHALL have parameter SEED, default 32'hA5A5_0000, meaning the background data pattern.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-007 The block SHALL have status outputs busy (1 bit), done (1-cycle pulse), pass (1 bit) and fail_addr (AW bits): run in progress, run finished, result, first failing address.
REQ-008 The block SHALL have RAM write-side outputs we (1 bit), addrw (AW bits) and dinw (DW bits).
REQ-009 The block SHALL have RAM read-side outputs addr1 and addr2 (AW bits each) and inputs dout1 and dout2 (DW bits each).

Function
REQ-010 Pattern SHALL be pat(a) = SEED ^ zero-extended a; phase-1 data SHALL be ~pat(a).
REQ-011 States SHALL be IDLE, W0, R0, W1, R1, DONE.
REQ-012 IDLE to W0 SHALL occur when start=1 at a clock edge; start SHALL be ignored in every other state.
REQ-013 W0: 2048 cycles; we=1, addrw=a, dinw=pat(a), a ascending 0..2047.
REQ-014 R0: 1024 issue cycles; addr1=a, addr2=a+1024, a ascending 0..1023; then 1 drain cycle.
REQ-015 W1: 2048 cycles; we=1, addrw=a, dinw=~pat(a), a descending 2047..0.
REQ-016 R1: same as R0, compared against ~pat().
REQ-017 RAM read latency SHALL be 1 cycle; dout1/dout2 SHALL be compared in the cycle after issue against the address registered at issue.
REQ-018 Outside W0/W1, we, addrw and dinw SHALL be 0; outside R0/R1 issue cycles, addr1 and addr2 SHALL be 0.
REQ-019 busy SHALL be 1 in W0 through R1.
REQ-020 DONE SHALL last 1 cycle, with done=1, then go to IDLE.
REQ-021 done SHALL assert exactly 6146 edges after the edge that sampled start.
REQ-022 pass SHALL update in DONE to 1 if no mismatch occurred, and SHALL hold until the next run.
REQ-023 fail_addr SHALL capture the address of the first mismatch; if both ports miss in the same cycle, port 1's address SHALL be captured.
REQ-024 A new start SHALL clear fail_addr and the internal error flag.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE and drive all outputs to 0 (including we, busy, done, pass, fail_addr, and err_cnt when present), including mid-run; no further RAM writes SHALL occur until the next start.

Configuration
REQ-026 With BIST_ERR_CNT_EN defined, output err_cnt[15:0] SHALL exist, count mismatches (2 if both ports miss in one cycle), saturate at 16'hFFFF, clear on start, and the run SHALL always complete the full 6146 cycles.
REQ-027 Without BIST_ERR_CNT_EN, err_cnt SHALL be absent and the first mismatch SHALL abort to DONE on the next edge with pass=0.

Structure
REQ-028 Package ram_bist_pkg SHALL hold AW, DW, DEPTH, HALF, the state enum and the pat() function.
REQ-029 Sub-module ram_bist_cmp SHALL implement the 1-cycle issue-to-compare pipeline (valid, expected data, addresses, mismatch flags).

Verification
REQ-030 Clean run: bench connects ram_2R1W (clk/rst shared); start pulse -> done exactly 6146 cycles later, pass=1, fail_addr=0.
REQ-031 Stuck bit: force dout2[5]=1 when addr2=1030 during R0 -> pass=0, fail_addr=1030; with BIST_ERR_CNT_EN, err_cnt=1.
REQ-032 Dual miss: corrupt dout1 at addr 3 and dout2 at addr 1027 in the same R1 cycle -> fail_addr=3; with BIST_ERR_CNT_EN, err_cnt=2; without it, done occurs the cycle after the miss.
REQ-033 Reset mid-run: assert rst at cycle 100 of W1 -> we=0 and busy=0 within the same cycle; after release, no write occurs until start.
REQ-034 Start while busy: pulse start at cycle 500 -> no effect, done still at 6146; check W1 addrw order 2047..0 and dinw=~pat.
